// File: rtl/approx_mult_pipe_pkg.sv
// Shared types and helpers for the pipelined approximate multiplier.
// approx_ref is the bit-level reference of the approximate product.
package approx_mult_pkg;

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Control part of every stage record; tag and data widths are per instance.
    typedef struct packed {
        logic valid;
        logic exact;
    } stage_ctl_t;

    function automatic int unsigned pw_of(input int unsigned width);
        return 2 * width;
    endfunction

    function automatic logic pp_bit(input logic [31:0] x, input logic [31:0] y,
                                    input int unsigned width, input int unsigned r,
                                    input int unsigned c);
        if (c < r || c - r >= width) return 1'b0;
        return x[5'(r)] & y[5'(c - r)];
    endfunction

    // Upper rows exact; low rows OR-merged in pairs and truncated below cut.
    function automatic logic [63:0] approx_ref(input logic [31:0] x, input logic [31:0] y,
                                               input int unsigned width, input int unsigned rows,
                                               input int unsigned cut);
        logic [63:0] acc;
        logic        bit_v;
        acc = '0;
        for (int unsigned r = rows; r < width; r++) begin
            if (x[5'(r)]) acc = acc + (64'(y) << r);
        end
        for (int unsigned c = cut; c < 2 * width; c++) begin
            for (int unsigned r = 0; r < rows; r += 2) begin
                bit_v = pp_bit(x, y, width, r, c);
                if (r + 1 < rows) bit_v = bit_v | pp_bit(x, y, width, r + 1, c);
                if (bit_v) acc = acc + (64'd1 << c);
            end
        end
        return acc & ((64'd1 << (2 * width)) - 64'd1);
    endfunction

endpackage

// File: rtl/approx_mult_pipe_if.sv
// Streaming operand/result bundle of the approximate multiplier.
interface approx_mult_pipe_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TAG_W = 4
);
    import approx_mult_pkg::*;

    localparam int unsigned PW = pw_of(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic             in_exact;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [PW-1:0]    out_z;
    logic [TAG_W-1:0] out_tag;
    logic [CNT_W-1:0] approx_cnt;

    modport slave (
        input  in_valid, in_x, in_y, in_exact, in_tag, out_ready,
        output in_ready, out_valid, out_z, out_tag, approx_cnt
    );

    modport master (
        output in_valid, in_x, in_y, in_exact, in_tag, out_ready,
        input  in_ready, out_valid, out_z, out_tag, approx_cnt
    );
endinterface

// File: rtl/approx_mult_pipe_compress.sv
// Partial-product compression: approximate row merging then a 3:2 CSA chain
// down to a sum/carry pair for the final adder.
module approx_pp_compress
    import approx_mult_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned APPROX_ROWS = 6,
    parameter int unsigned CUT         = 6
) (
    input  logic [WIDTH-1:0][WIDTH-1:0] rows,
    input  logic                        exact,
    output logic [pw_of(WIDTH)-1:0]     sum_c,
    output logic [pw_of(WIDTH)-1:0]     carry_c
);

    localparam int unsigned PW = pw_of(WIDTH);

    logic [PW-1:0]             cut_mask;
    logic [WIDTH-1:0][PW-1:0]  sh;
    logic [PW-1:0]             s_acc;
    logic [PW-1:0]             c_acc;
    logic [PW-1:0]             term;
    logic [PW-1:0]             nxt_c;

    always_comb begin
        cut_mask = ~((PW'(1) << CUT) - PW'(1));
        s_acc    = '0;
        c_acc    = '0;
        term     = '0;
        nxt_c    = '0;
        for (int unsigned r = 0; r < WIDTH; r++) begin
            sh[r] = PW'(rows[r]) << r;
        end
        for (int unsigned r = 0; r < WIDTH; r++) begin
            int unsigned nb;
            nb   = (r + 1 < WIDTH) ? r + 1 : r;
            term = sh[r];
            // Even row of a pair carries the merged pair; odd row is absorbed.
            if (!exact && r < APPROX_ROWS) begin
                if (r % 2 == 1)             term = '0;
                else if (r + 1 < APPROX_ROWS) term = (sh[r] | sh[nb]) & cut_mask;
                else                        term = sh[r] & cut_mask;
            end
            nxt_c = ((s_acc & c_acc) | (s_acc & term) | (c_acc & term)) << 1;
            s_acc = s_acc ^ c_acc ^ term;
            c_acc = nxt_c;
        end
        sum_c   = s_acc;
        carry_c = c_acc;
    end

endmodule

// File: rtl/approx_mult_pipe.sv
// Three-stage valid/ready approximate multiplier: PP rows -> compression ->
// final add, with a saturating count of delivered approximate results.
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned APPROX_ROWS = 6,
    parameter int unsigned CUT         = 6,
    parameter int unsigned TAG_W       = 4
) (
    input logic               clk,
    input logic               rst,
    approx_mult_pipe_if.slave bus
);

    localparam int unsigned PW = pw_of(WIDTH);

    typedef struct packed {
        stage_ctl_t                  ctl;
        logic [TAG_W-1:0]            tag;
        logic [WIDTH-1:0][WIDTH-1:0] rows;
    } s1_t;

    typedef struct packed {
        stage_ctl_t       ctl;
        logic [TAG_W-1:0] tag;
        logic [PW-1:0]    sum;
        logic [PW-1:0]    carry;
    } s2_t;

    typedef struct packed {
        stage_ctl_t       ctl;
        logic [TAG_W-1:0] tag;
        logic [PW-1:0]    z;
    } s3_t;

    s1_t              s1_q, s1_d;
    s2_t              s2_q, s2_d;
    s3_t              s3_q, s3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic                        s1_free, s2_free, s3_free, consume;
    logic [WIDTH-1:0][WIDTH-1:0] in_rows;
    logic [PW-1:0]               sum_c, carry_c;

    approx_pp_compress #(
        .WIDTH      (WIDTH),
        .APPROX_ROWS(APPROX_ROWS),
        .CUT        (CUT)
    ) u_compress (
        .rows   (s1_q.rows),
        .exact  (s1_q.ctl.exact),
        .sum_c  (sum_c),
        .carry_c(carry_c)
    );

    // A stage may load when it is empty or its content moves on this cycle.
    always_comb begin
        s3_free = !s3_q.ctl.valid || bus.out_ready;
        s2_free = !s2_q.ctl.valid || s3_free;
        s1_free = !s1_q.ctl.valid || s2_free;
        consume = s3_q.ctl.valid && bus.out_ready;
        for (int unsigned r = 0; r < WIDTH; r++) begin
            in_rows[r] = bus.in_x[r] ? bus.in_y : '0;
        end
    end

    // Data fields hold when a stage goes empty so out_z never moves unconsumed.
    always_comb begin
        s1_d  = s1_q;
        s2_d  = s2_q;
        s3_d  = s3_q;
        cnt_d = cnt_q;
        if (s1_free) begin
            s1_d.ctl.valid = bus.in_valid;
            if (bus.in_valid) begin
                s1_d.ctl.exact = bus.in_exact;
                s1_d.tag       = bus.in_tag;
                s1_d.rows      = in_rows;
            end
        end
        if (s2_free) begin
            s2_d.ctl.valid = s1_q.ctl.valid;
            if (s1_q.ctl.valid) begin
                s2_d.ctl.exact = s1_q.ctl.exact;
                s2_d.tag       = s1_q.tag;
                s2_d.sum       = sum_c;
                s2_d.carry     = carry_c;
            end
        end
        if (s3_free) begin
            s3_d.ctl.valid = s2_q.ctl.valid;
            if (s2_q.ctl.valid) begin
                s3_d.ctl.exact = s2_q.ctl.exact;
                s3_d.tag       = s2_q.tag;
                s3_d.z         = s2_q.sum + s2_q.carry;
            end
        end
        if (consume && !s3_q.ctl.exact && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= '0;
            s2_q  <= '0;
            s3_q  <= '0;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            s3_q  <= s3_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.in_ready   = s1_free;
    assign bus.out_valid  = s3_q.ctl.valid;
    assign bus.out_z      = s3_q.z;
    assign bus.out_tag    = s3_q.tag;
    assign bus.approx_cnt = cnt_q;

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Bench for approx_mult_pipe: directed products, random streaming, stalls,
// mid-flight reset and counter saturation against a queue-based model.
module tb_approx_mult_pipe;
    import approx_mult_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned AR    = 6;
    localparam int unsigned CUT   = 6;
    localparam int unsigned TAG_W = 4;

    typedef struct {
        logic [15:0] z;
        logic [3:0]  tag;
        logic        ex;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   err = 0;
    int   chk = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    approx_mult_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    approx_mult_pipe #(
        .WIDTH(WIDTH), .APPROX_ROWS(AR), .CUT(CUT), .TAG_W(TAG_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [15:0] model_z(input logic [7:0] x, input logic [7:0] y, input logic ex);
        logic [63:0] r;
        if (ex) return 16'(32'(x) * 32'(y));
        r = approx_ref(32'(x), 32'(y), WIDTH, AR, CUT);
        return r[15:0];
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        e.z   = model_z(bus.in_x, bus.in_y, bus.in_exact);
        e.tag = bus.in_tag;
        e.ex  = bus.in_exact;
        return e;
    endfunction

    task automatic bump_cnt(input logic ex);
        if (!ex && exp_cnt < 65535) exp_cnt++;
    endtask

    task automatic drive_rand();
        bus.in_x     = 8'($urandom);
        bus.in_y     = 8'($urandom);
        bus.in_exact = 1'($urandom);
        bus.in_tag   = 4'($urandom);
        bus.in_valid = 1'b1;
    endtask

    // Single beat into an idle pipe; returns what came out and when.
    task automatic send_one(input logic [7:0] x, input logic [7:0] y, input logic ex,
                            input logic [3:0] tg, output logic [15:0] z,
                            output logic [3:0] to, output int lat, output logic rdy);
        bus.in_x = x; bus.in_y = y; bus.in_exact = ex; bus.in_tag = tg; bus.in_valid = 1'b1;
        @(negedge clk);
        rdy = bus.in_ready;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = -1; z = '0; to = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = i; z = bus.out_z; to = bus.out_tag;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        chk++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
        chk++; if (bus.out_z !== 16'd0) begin err++; $display("FAIL reset_out_z got %0d want 0", bus.out_z); end
        chk++; if (bus.out_tag !== 4'd0) begin err++; $display("FAIL reset_out_tag got %0d want 0", bus.out_tag); end
        chk++; if (bus.approx_cnt !== 16'd0) begin err++; $display("FAIL reset_cnt got %0d want 0", bus.approx_cnt); end
        chk++; if (bus.in_ready !== 1'b1) begin err++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [7:0]  xs [7];
        logic [7:0]  ys [7];
        logic        es [7];
        logic [15:0] zs [7];
        logic [15:0] z;
        logic [3:0]  to;
        int          lat;
        logic        rdy;
        xs = '{8'd255, 8'd255, 8'd1, 8'd192, 8'd192, 8'd0, 8'd0};
        ys = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'($urandom), 8'($urandom)};
        es = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        zs = '{16'd59520, 16'd65025, 16'd192, 16'd48960, 16'd48960, 16'd0, 16'd0};
        for (int i = 0; i < 7; i++) begin
            send_one(xs[i], ys[i], es[i], 4'(i + 3), z, to, lat, rdy);
            chk++; if (rdy !== 1'b1) begin err++; $display("FAIL dir_ready[%0d] got %0b want 1", i, rdy); end
            chk++; if (z !== zs[i]) begin err++; $display("FAIL dir_z[%0d] x=%0d y=%0d ex=%0b got %0d want %0d", i, xs[i], ys[i], es[i], z, zs[i]); end
            chk++; if (to !== 4'(i + 3)) begin err++; $display("FAIL dir_tag[%0d] got %0d want %0d", i, to, i + 3); end
            chk++; if (lat != 3) begin err++; $display("FAIL dir_latency[%0d] got %0d want 3", i, lat); end
            bump_cnt(es[i]);
            if (i == 1) begin
                @(negedge clk);
                chk++; if (bus.approx_cnt !== 16'(exp_cnt)) begin err++; $display("FAIL dir_cnt_first got %0d want %0d", bus.approx_cnt, exp_cnt); end
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        chk++; if (bus.approx_cnt !== 16'(exp_cnt)) begin err++; $display("FAIL dir_cnt got %0d want %0d", bus.approx_cnt, exp_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        int   sent = 0, got = 0, gaps = 0, cyc = 0, stalls = 0;
        bus.out_ready = 1'b1;
        drive_rand();
        while (got < 100 && cyc < 400) begin
            @(negedge clk); cyc++;
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk++; err++; $display("FAIL b2b_spurious z=%0d want no output", bus.out_z);
                end else begin
                    e = q.pop_front();
                    chk++; if (bus.out_z !== e.z) begin err++; $display("FAIL b2b_z[%0d] got %0d want %0d", got, bus.out_z, e.z); end
                    chk++; if (bus.out_tag !== e.tag) begin err++; $display("FAIL b2b_tag[%0d] got %0d want %0d", got, bus.out_tag, e.tag); end
                    bump_cnt(e.ex);
                    got++;
                end
            end else if (got > 0) gaps++;
            if (bus.in_valid && !bus.in_ready) stalls++;
            if (bus.in_valid && bus.in_ready) begin q.push_back(expect_now()); sent++; end
            @(posedge clk); #1;
            if (sent < 100) drive_rand(); else bus.in_valid = 1'b0;
        end
        chk++; if (got != 100) begin err++; $display("FAIL b2b_count got %0d want 100", got); end
        chk++; if (gaps != 0) begin err++; $display("FAIL b2b_gaps got %0d want 0", gaps); end
        chk++; if (stalls != 0) begin err++; $display("FAIL b2b_in_stalls got %0d want 0", stalls); end
        @(negedge clk);
        chk++; if (bus.approx_cnt !== 16'(exp_cnt)) begin err++; $display("FAIL b2b_cnt got %0d want %0d", bus.approx_cnt, exp_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        exp_t        q[$];
        exp_t        e;
        int          acc = 0, moved = 0, got = 0, extra = 0, cyc = 0;
        logic        last_rdy = 1'b1, have = 1'b0, first = 1'b1;
        logic [15:0] hz = '0;
        logic [3:0]  ht = '0;
        bus.out_ready = 1'b0;
        drive_rand();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                if (!have) begin have = 1'b1; hz = bus.out_z; ht = bus.out_tag; end
                else if (bus.out_z !== hz || bus.out_tag !== ht) moved++;
            end
            last_rdy = bus.in_ready;
            if (bus.in_valid && bus.in_ready) begin q.push_back(expect_now()); acc++; end
            @(posedge clk); #1;
            if (last_rdy) drive_rand();
        end
        chk++; if (acc != 3) begin err++; $display("FAIL stall_accepted got %0d want 3", acc); end
        chk++; if (last_rdy !== 1'b0) begin err++; $display("FAIL stall_in_ready got %0b want 0", last_rdy); end
        chk++; if (have !== 1'b1) begin err++; $display("FAIL stall_out_valid got %0b want 1", have); end
        chk++; if (moved != 0) begin err++; $display("FAIL stall_out_stable changes %0d want 0", moved); end
        bus.out_ready = 1'b1;
        while (cyc < 100) begin
            @(negedge clk); cyc++;
            if (first) begin
                first = 1'b0;
                chk++; if (bus.in_ready !== 1'b1) begin err++; $display("FAIL full_accept_consume in_ready got %0b want 1", bus.in_ready); end
            end
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk++; err++; $display("FAIL stall_spurious z=%0d want no output", bus.out_z);
                end else begin
                    e = q.pop_front();
                    chk++; if (bus.out_z !== e.z) begin err++; $display("FAIL stall_z[%0d] got %0d want %0d", got, bus.out_z, e.z); end
                    chk++; if (bus.out_tag !== e.tag) begin err++; $display("FAIL stall_tag[%0d] got %0d want %0d", got, bus.out_tag, e.tag); end
                    bump_cnt(e.ex);
                    got++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin q.push_back(expect_now()); extra++; end
            @(posedge clk); #1;
            if (extra < 4) drive_rand(); else bus.in_valid = 1'b0;
            if (extra >= 4 && q.size() == 0) break;
        end
        chk++; if (got != 7) begin err++; $display("FAIL stall_drain_count got %0d want 7", got); end
        @(negedge clk);
        chk++; if (bus.approx_cnt !== 16'(exp_cnt)) begin err++; $display("FAIL stall_cnt got %0d want %0d", bus.approx_cnt, exp_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int n = 0, seen = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_rand();
            bus.in_exact = 1'b0;
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) n++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk++; if (n != 3) begin err++; $display("FAIL rstmid_accepted got %0d want 3", n); end
        chk++; if (bus.out_valid !== 1'b1) begin err++; $display("FAIL rstmid_pre_valid got %0b want 1", bus.out_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        chk++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL rstmid_out_valid got %0b want 0", bus.out_valid); end
        chk++; if (bus.approx_cnt !== 16'd0) begin err++; $display("FAIL rstmid_cnt got %0d want 0", bus.approx_cnt); end
        chk++; if (bus.in_ready !== 1'b1) begin err++; $display("FAIL rstmid_in_ready got %0b want 1", bus.in_ready); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk++; if (seen != 0) begin err++; $display("FAIL rstmid_leak got %0d outputs want 0", seen); end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        logic        q[$];
        logic        ex;
        int          sent = 0, got = 0, cyc = 0, bad = 0, bad_want = 0;
        logic [15:0] bad_got = '0;
        bus.out_ready = 1'b1;
        drive_rand();
        bus.in_exact = 1'b0;
        while (got < 70020 && cyc < 71000) begin
            @(negedge clk); cyc++;
            if (bus.approx_cnt !== 16'(exp_cnt)) begin
                if (bad == 0) begin bad_got = bus.approx_cnt; bad_want = exp_cnt; end
                bad++;
            end
            if (bus.out_valid) begin
                if (q.size() > 0) begin ex = q.pop_front(); bump_cnt(ex); end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin q.push_back(bus.in_exact); sent++; end
            @(posedge clk); #1;
            if (sent < 70020) begin
                bus.in_x = 8'($urandom); bus.in_y = 8'($urandom);
                bus.in_exact = (sent >= 70000); bus.in_valid = 1'b1;
            end else bus.in_valid = 1'b0;
        end
        chk++; if (got != 70020) begin err++; $display("FAIL sat_count got %0d want 70020", got); end
        chk++; if (bad != 0) begin err++; $display("FAIL sat_track %0d cycles off, first got %0d want %0d", bad, bad_got, bad_want); end
        @(negedge clk);
        chk++; if (bus.approx_cnt !== 16'hFFFF) begin err++; $display("FAIL sat_final got %0h want ffff", bus.approx_cnt); end
        @(posedge clk); #1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog expired after %0d checks", chk);
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0;
        bus.in_exact = 1'b0; bus.in_tag = '0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end

endmodule
